// File: rtl/sn_cfg_pkg.sv
// Shared register map, CTRL/status bit positions and sizing helpers for the
// synaptic weight table loader.
package sn_cfg_pkg;

    typedef enum logic [1:0] {
        REG_TABLE_SEL = 2'd0,
        REG_ROW_PTR   = 2'd1,
        REG_DATA      = 2'd2,
        REG_CTRL      = 2'd3
    } reg_off_e;

    localparam int CTRL_COMMIT_BIT  = 0;
    localparam int CTRL_CLEAR_BIT   = 1;
    localparam int CTRL_ERRCLR_BIT  = 2;

    localparam int STAT_PARTIAL_BIT = 0;
    localparam int STAT_DIRTY_BIT   = 2;
    localparam int STAT_ERR_BIT     = 3;

    function automatic int bytes_per_entry(input int bw);
        return (bw + 7) / 8;
    endfunction

    // Index width for a counter over n values, never narrower than one bit.
    function automatic int ptr_bw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sn_cfg_byte_assembler.sv
// Collects LSB-first byte writes into one table entry and strobes entry_done_o
// on the byte that completes it.
module sn_cfg_byte_assembler
    import sn_cfg_pkg::*;
#(
    parameter int P_ENTRY_BW = 10
) (
    input  logic                                              clk,
    input  logic                                              rst,
    input  logic                                              clear_i,
    input  logic                                              step_i,
    input  logic                                              load_i,
    input  logic [7:0]                                        wdata_i,
    output logic [ptr_bw(bytes_per_entry(P_ENTRY_BW))-1:0]    byte_ptr_o,
    output logic [P_ENTRY_BW-1:0]                             entry_o,
    output logic                                              entry_done_o
);

    localparam int NB = bytes_per_entry(P_ENTRY_BW);
    localparam int PW = ptr_bw(NB);

    logic [NB*8-1:0] stage_q, stage_d, merged;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic            last;

    assign last = (ptr_q == PW'(NB - 1));

    // The completing byte is merged combinationally so the entry is ready on its own edge.
    always_comb begin
        merged = stage_q;
        merged[ptr_q*8 +: 8] = wdata_i;
    end

    always_comb begin
        stage_d = stage_q;
        ptr_d   = ptr_q;
        if (clear_i) begin
            stage_d = '0;
            ptr_d   = '0;
        end else if (step_i) begin
            if (load_i) begin
                stage_d = merged;
            end
            if (last) begin
                stage_d = '0;
                ptr_d   = '0;
            end else begin
                ptr_d = ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_q <= '0;
            ptr_q   <= '0;
        end else begin
            stage_q <= stage_d;
            ptr_q   <= ptr_d;
        end
    end

    assign byte_ptr_o   = ptr_q;
    assign entry_o      = merged[P_ENTRY_BW-1:0];
    assign entry_done_o = step_i && last;

endmodule

// File: rtl/sn_cfg_table_loader.sv
// Runtime shadow/active weight-table loader on the prot_* register bus.
// Define SN_CFG_READBACK_EN to build the shadow readback path on the DATA register.
module sn_cfg_table_loader
    import sn_cfg_pkg::*;
#(
    parameter int         P_NUM_NEURONS        = 5,
    parameter int         P_NUM_INPUTS         = 2,
    parameter int         P_NUM_OUTPUTS        = 1,
    parameter int         P_TABLE_MAX_NUM_ROWS = 10,
    parameter int         P_TABLE_WEIGHT_BW    = 7,
    parameter logic [6:0] P_BASE_ADDR          = 7'h60
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       prot_enable,
    input  logic       prot_r0w1,
    input  logic [6:0] prot_addr,
    input  logic [7:0] prot_wdata,
    output logic [7:0] prot_rdata,
    output logic       prot_hit,
    output logic [P_NUM_NEURONS-P_NUM_INPUTS:1][P_TABLE_MAX_NUM_ROWS-1:0]
                 [P_TABLE_WEIGHT_BW+$clog2(P_NUM_NEURONS-P_NUM_OUTPUTS+1)-1:0] cfg_table_contents,
    output logic       cfg_update
);

    localparam int L_TABLE_IDX_BW    = $clog2(P_NUM_NEURONS - P_NUM_OUTPUTS + 1);
    localparam int L_ENTRY_BW        = P_TABLE_WEIGHT_BW + L_TABLE_IDX_BW;
    localparam int L_BYTES_PER_ENTRY = bytes_per_entry(L_ENTRY_BW);
    localparam int L_NUM_TABLES      = P_NUM_NEURONS - P_NUM_INPUTS;
    localparam int SEL_BW            = ptr_bw(L_NUM_TABLES + 1);
    localparam int ROW_BW            = ptr_bw(P_TABLE_MAX_NUM_ROWS);
    localparam int BP_BW             = ptr_bw(L_BYTES_PER_ENTRY);

    typedef logic [L_NUM_TABLES:1][P_TABLE_MAX_NUM_ROWS-1:0][L_ENTRY_BW-1:0] tab_t;

    tab_t              shadow_q, active_q;
    logic [SEL_BW-1:0] sel_q;
    logic [ROW_BW-1:0] row_ptr_q;
    logic              err_q, dirty_q, upd_q;

    logic [7:0]            addr_diff;
    reg_off_e              off;
    logic                  wr_en, sel_ok, row_ok;
    logic                  data_load, data_step, asm_clear, entry_done;
    logic [L_ENTRY_BW-1:0] entry;
    logic [BP_BW-1:0]      byte_ptr;
    logic [7:0]            rb_byte;

    // Addresses below the base wrap to large differences, so one compare covers both bounds.
    assign addr_diff = {1'b0, prot_addr} - {1'b0, P_BASE_ADDR};
    assign prot_hit  = (addr_diff < 8'd4);
    assign off       = reg_off_e'(addr_diff[1:0]);
    assign wr_en     = prot_enable && prot_hit && prot_r0w1;

    assign sel_ok    = (prot_wdata != 8'd0) && (32'(prot_wdata) <= L_NUM_TABLES);
    assign row_ok    = (32'(prot_wdata) < P_TABLE_MAX_NUM_ROWS);
    assign data_load = wr_en && (off == REG_DATA);
    assign asm_clear = wr_en && (((off == REG_TABLE_SEL) && sel_ok) ||
                                 ((off == REG_ROW_PTR) && row_ok));

`ifdef SN_CFG_READBACK_EN
    logic [L_BYTES_PER_ENTRY*8-1:0] rb_entry;

    assign data_step = data_load ||
                       (prot_enable && prot_hit && !prot_r0w1 && (off == REG_DATA));

    always_comb begin
        rb_entry = '0;
        rb_entry[L_ENTRY_BW-1:0] = shadow_q[sel_q][row_ptr_q];
    end

    assign rb_byte = rb_entry[byte_ptr*8 +: 8];
`else
    assign data_step = data_load;
    assign rb_byte   = 8'h00;
`endif

    sn_cfg_byte_assembler #(
        .P_ENTRY_BW (L_ENTRY_BW)
    ) u_asm (
        .clk          (clk),
        .rst          (rst),
        .clear_i      (asm_clear),
        .step_i       (data_step),
        .load_i       (data_load),
        .wdata_i      (prot_wdata),
        .byte_ptr_o   (byte_ptr),
        .entry_o      (entry),
        .entry_done_o (entry_done)
    );

    always_comb begin
        prot_rdata = 8'h00;
        if (prot_hit) begin
            case (off)
                REG_TABLE_SEL: prot_rdata = 8'(sel_q);
                REG_ROW_PTR:   prot_rdata = 8'(row_ptr_q);
                REG_DATA:      prot_rdata = rb_byte;
                REG_CTRL: begin
                    prot_rdata[STAT_ERR_BIT]     = err_q;
                    prot_rdata[STAT_DIRTY_BIT]   = dirty_q;
                    prot_rdata[STAT_PARTIAL_BIT] = (byte_ptr != '0);
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_q  <= '0;
            active_q  <= '0;
            sel_q     <= SEL_BW'(1);
            row_ptr_q <= '0;
            err_q     <= 1'b0;
            dirty_q   <= 1'b0;
            upd_q     <= 1'b0;
        end else begin
            upd_q <= 1'b0;
            if (entry_done) begin
                row_ptr_q <= (row_ptr_q == ROW_BW'(P_TABLE_MAX_NUM_ROWS - 1)) ? '0
                                                                             : row_ptr_q + 1'b1;
                if (data_load) begin
                    shadow_q[sel_q][row_ptr_q] <= entry;
                    dirty_q                    <= 1'b1;
                end
            end
            if (wr_en) begin
                case (off)
                    REG_TABLE_SEL: begin
                        if (sel_ok) begin
                            sel_q     <= prot_wdata[SEL_BW-1:0];
                            row_ptr_q <= '0;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                    REG_ROW_PTR: begin
                        if (row_ok) row_ptr_q <= prot_wdata[ROW_BW-1:0];
                        else        err_q     <= 1'b1;
                    end
                    // Commit reads the pre-clear shadow, so COMMIT|CLEAR publishes then wipes.
                    REG_CTRL: begin
                        if (prot_wdata[CTRL_COMMIT_BIT]) begin
                            active_q <= shadow_q;
                            dirty_q  <= 1'b0;
                            upd_q    <= 1'b1;
                        end
                        if (prot_wdata[CTRL_CLEAR_BIT]) begin
                            shadow_q <= '0;
                            dirty_q  <= 1'b1;
                        end
                        if (prot_wdata[CTRL_ERRCLR_BIT]) begin
                            err_q <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign cfg_table_contents = active_q;
    assign cfg_update         = upd_q;

endmodule

// File: tb/tb_sn_cfg_table_loader.sv
// Self-checking bench for sn_cfg_table_loader (default parameters) with an
// abstract register/table reference model.
module tb_sn_cfg_table_loader;

    typedef logic [3:1][9:0][9:0] tab_t;

    typedef struct {
        bit         w;
        logic [6:0] a;
        logic [7:0] d;
        bit         chk;
        logic [7:0] exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       prot_enable = 1'b0;
    logic       prot_r0w1 = 1'b0;
    logic [6:0] prot_addr = '0;
    logic [7:0] prot_wdata = '0;
    logic [7:0] prot_rdata;
    logic       prot_hit;
    tab_t       cfg_table_contents;
    logic       cfg_update;

    int n_checks = 0;
    int n_fail   = 0;

    int m_sh [1:3][0:9];
    int m_act[1:3][0:9];
    int m_sel, m_row, m_bp, m_stage;
    bit m_err, m_dirty;

    vec_t vecs[$];

    always #5 clk = ~clk;

    sn_cfg_table_loader dut (
        .clk                (clk),
        .rst                (rst),
        .prot_enable        (prot_enable),
        .prot_r0w1          (prot_r0w1),
        .prot_addr          (prot_addr),
        .prot_wdata         (prot_wdata),
        .prot_rdata         (prot_rdata),
        .prot_hit           (prot_hit),
        .cfg_table_contents (cfg_table_contents),
        .cfg_update         (cfg_update)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic chk_tab(input string nm, input tab_t act, input tab_t exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int t = 1; t <= 3; t++)
            for (int r = 0; r < 10; r++) begin
                m_sh[t][r]  = 0;
                m_act[t][r] = 0;
            end
        m_sel = 1; m_row = 0; m_bp = 0; m_stage = 0;
        m_err = 0; m_dirty = 0;
    endtask

    function automatic tab_t model_active();
        tab_t v;
        for (int t = 1; t <= 3; t++)
            for (int r = 0; r < 10; r++)
                v[t][r] = 10'(m_act[t][r]);
        return v;
    endfunction

    // Two bytes make one 10-bit entry; the row pointer walks 0..9 and wraps.
    task automatic model_advance(input bit store);
        if (m_bp == 1) begin
            if (store) begin
                m_sh[m_sel][m_row] = m_stage & 'h3FF;
                m_dirty = 1;
            end
            m_stage = 0;
            m_bp    = 0;
            m_row   = (m_row + 1) % 10;
        end else begin
            m_bp++;
        end
    endtask

    task automatic model_step(input bit w, input logic [6:0] a, input logic [7:0] d,
                              output logic [7:0] rd, output logic hit, output logic upd);
        int off;
        rd  = 8'h00;
        upd = 1'b0;
        hit = (a >= 7'h60) && (a <= 7'h63);
        if (!hit) return;
        off = int'(a) - 'h60;
        case (off)
            0: rd = 8'(m_sel);
            1: rd = 8'(m_row);
            2: begin
`ifdef SN_CFG_READBACK_EN
                rd = 8'((m_sh[m_sel][m_row] >> (8 * m_bp)) & 255);
`endif
            end
            default: rd = 8'((m_err ? 8 : 0) + (m_dirty ? 4 : 0) + ((m_bp != 0) ? 1 : 0));
        endcase
        if (!w) begin
`ifdef SN_CFG_READBACK_EN
            if (off == 2) model_advance(1'b0);
`endif
            return;
        end
        case (off)
            0: begin
                if (d >= 1 && d <= 3) begin
                    m_sel = int'(d); m_row = 0; m_bp = 0; m_stage = 0;
                end else m_err = 1;
            end
            1: begin
                if (d < 10) begin
                    m_row = int'(d); m_bp = 0; m_stage = 0;
                end else m_err = 1;
            end
            2: begin
                m_stage = m_stage | (int'(d) << (8 * m_bp));
                model_advance(1'b1);
            end
            default: begin
                if (d[0]) begin
                    for (int t = 1; t <= 3; t++)
                        for (int r = 0; r < 10; r++)
                            m_act[t][r] = m_sh[t][r];
                    m_dirty = 0;
                    upd = 1'b1;
                end
                if (d[1]) begin
                    for (int t = 1; t <= 3; t++)
                        for (int r = 0; r < 10; r++)
                            m_sh[t][r] = 0;
                    m_dirty = 1;
                end
                if (d[2]) m_err = 0;
            end
        endcase
    endtask

    // One bus transaction per cycle; rdata sampled mid-cycle, state after the edge.
    task automatic run(input bit w, input logic [6:0] a, input logic [7:0] d,
                       input string nm, output logic [7:0] rd);
        logic [7:0] mrd;
        logic       mhit, mupd, hit;
        @(negedge clk);
        prot_enable = 1'b1;
        prot_r0w1   = w;
        prot_addr   = a;
        prot_wdata  = d;
        #1;
        rd  = prot_rdata;
        hit = prot_hit;
        @(posedge clk);
        #1;
        prot_enable = 1'b0;
        model_step(w, a, d, mrd, mhit, mupd);
        chk({nm, " rdata"}, 32'(rd), 32'(mrd));
        chk({nm, " hit"}, 32'(hit), 32'(mhit));
        chk({nm, " cfg_update"}, 32'(cfg_update), 32'(mupd));
        chk_tab({nm, " tables"}, cfg_table_contents, model_active());
    endtask

    function automatic void add(input bit w, input logic [6:0] a, input logic [7:0] d,
                                input bit c, input logic [7:0] e);
        vecs.push_back('{w, a, d, c, e});
    endfunction

    initial begin
        logic [7:0] rd;
        logic [6:0] a;
        logic [7:0] d;
        bit         w;
        int         k;

        add(0, 7'h60, 8'h00, 1, 8'h01);
        add(0, 7'h63, 8'h00, 1, 8'h00);
        add(0, 7'h61, 8'h00, 1, 8'h00);
        add(0, 7'h5F, 8'h00, 1, 8'h00);
        add(1, 7'h5F, 8'h03, 0, 8'h00);
        add(0, 7'h64, 8'h00, 1, 8'h00);
        add(1, 7'h60, 8'h02, 0, 8'h00);
        add(1, 7'h62, 8'hAB, 0, 8'h00);
        add(0, 7'h63, 8'h00, 1, 8'h01);
        add(1, 7'h62, 8'hFF, 0, 8'h00);
        add(0, 7'h61, 8'h00, 1, 8'h01);
        add(0, 7'h63, 8'h00, 1, 8'h04);
        add(1, 7'h63, 8'h01, 0, 8'h00);
        add(1, 7'h61, 8'h09, 0, 8'h00);
        add(1, 7'h62, 8'h11, 0, 8'h00);
        add(1, 7'h62, 8'h00, 0, 8'h00);
        add(1, 7'h62, 8'h22, 0, 8'h00);
        add(1, 7'h62, 8'h00, 0, 8'h00);
        add(0, 7'h61, 8'h00, 1, 8'h01);
        add(1, 7'h60, 8'h04, 0, 8'h00);
        add(0, 7'h60, 8'h00, 1, 8'h02);
        add(1, 7'h61, 8'h0A, 0, 8'h00);
        add(0, 7'h61, 8'h00, 1, 8'h01);
        add(0, 7'h63, 8'h00, 1, 8'h0C);
        add(1, 7'h63, 8'h04, 0, 8'h00);
        add(0, 7'h63, 8'h00, 1, 8'h04);
        add(1, 7'h60, 8'h00, 0, 8'h00);
        add(0, 7'h60, 8'h00, 1, 8'h02);
        add(0, 7'h63, 8'h00, 1, 8'h0C);
        add(1, 7'h63, 8'h04, 0, 8'h00);
        add(1, 7'h62, 8'h55, 0, 8'h00);
        add(0, 7'h63, 8'h00, 1, 8'h05);
        add(1, 7'h61, 8'h03, 0, 8'h00);
        add(0, 7'h63, 8'h00, 1, 8'h04);
        add(1, 7'h62, 8'h11, 0, 8'h00);
        add(1, 7'h62, 8'h02, 0, 8'h00);
        add(0, 7'h61, 8'h00, 1, 8'h04);
        add(0, 7'h63, 8'h00, 1, 8'h04);

        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset cfg_update", 32'(cfg_update), 32'd0);
        chk_tab("reset tables", cfg_table_contents, '0);

        foreach (vecs[i]) begin
            run(vecs[i].w, vecs[i].a, vecs[i].d, $sformatf("vec%0d", i), rd);
            if (vecs[i].chk) chk($sformatf("vec%0d const rdata", i), 32'(rd), 32'(vecs[i].exp));
        end

        chk("active[2][0] first commit", 32'(cfg_table_contents[2][0]), 32'h3AB);
        chk("active[2][9] before commit", 32'(cfg_table_contents[2][9]), 32'h000);

        run(1, 7'h63, 8'h01, "commit2", rd);
        chk("commit2 update", 32'(cfg_update), 32'd1);
        chk("active[2][9]", 32'(cfg_table_contents[2][9]), 32'h011);
        chk("active[2][0]", 32'(cfg_table_contents[2][0]), 32'h022);
        chk("active[2][3]", 32'(cfg_table_contents[2][3]), 32'h211);
        @(posedge clk);
        #1;
        chk("update pulse width", 32'(cfg_update), 32'd0);

        run(1, 7'h63, 8'h01, "b2b commit a", rd);
        chk("b2b update a", 32'(cfg_update), 32'd1);
        run(1, 7'h63, 8'h01, "b2b commit b", rd);
        chk("b2b update b", 32'(cfg_update), 32'd1);

        run(1, 7'h62, 8'h55, "pre-reset byte", rd);
        run(1, 7'h63, 8'h01, "pre-reset commit", rd);
        #2;
        rst = 1'b1;
        #1;
        chk("async reset cfg_update", 32'(cfg_update), 32'd0);
        chk_tab("async reset tables", cfg_table_contents, '0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        run(0, 7'h63, 8'h00, "post-reset ctrl", rd);
        chk("post-reset ctrl const", 32'(rd), 32'h00);
        run(0, 7'h60, 8'h00, "post-reset sel", rd);
        chk("post-reset sel const", 32'(rd), 32'h01);

        run(1, 7'h60, 8'h01, "cc sel", rd);
        run(1, 7'h62, 8'h34, "cc b0", rd);
        run(1, 7'h62, 8'h01, "cc b1", rd);
        run(1, 7'h63, 8'h03, "commit+clear", rd);
        chk("commit+clear active[1][0]", 32'(cfg_table_contents[1][0]), 32'h134);
        run(0, 7'h63, 8'h00, "commit+clear status", rd);
        chk("commit+clear status const", 32'(rd), 32'h04);
        run(1, 7'h63, 8'h01, "commit cleared", rd);
        chk("cleared active[1][0]", 32'(cfg_table_contents[1][0]), 32'h000);

        run(1, 7'h60, 8'h02, "rb sel", rd);
        run(1, 7'h62, 8'hAB, "rb b0", rd);
        run(1, 7'h62, 8'hFF, "rb b1", rd);
        run(1, 7'h61, 8'h00, "rb row", rd);
        run(0, 7'h62, 8'h00, "rb read0", rd);
`ifdef SN_CFG_READBACK_EN
        chk("readback byte0", 32'(rd), 32'hAB);
`else
        chk("readback byte0", 32'(rd), 32'h00);
`endif
        run(0, 7'h62, 8'h00, "rb read1", rd);
`ifdef SN_CFG_READBACK_EN
        chk("readback byte1", 32'(rd), 32'h03);
`else
        chk("readback byte1", 32'(rd), 32'h00);
`endif
        run(0, 7'h61, 8'h00, "rb rowptr", rd);
`ifdef SN_CFG_READBACK_EN
        chk("readback rowptr", 32'(rd), 32'h01);
`else
        chk("readback rowptr", 32'(rd), 32'h00);
`endif

        for (int i = 0; i < 400; i++) begin
            w = 1'($urandom_range(0, 1));
            k = int'($urandom_range(0, 9));
            if (k < 9) a = 7'h60 + 7'(k % 4);
            else       a = 7'($urandom_range(0, 127));
            case (int'(a) - 'h60)
                0:       d = 8'($urandom_range(0, 5));
                1:       d = 8'($urandom_range(0, 12));
                3:       d = 8'($urandom_range(0, 7));
                default: d = 8'($urandom_range(0, 255));
            endcase
            run(w, a, d, $sformatf("rand%0d", i), rd);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sn_cfg_table_loader.md
# sn_cfg_table_loader

Runtime loader for the synaptic weight tables of `sn_network_cfg`. It sits on the `prot_*` bus beside the network and replaces the static `cfg_table_contents` input port with register storage written over UART. Entries are assembled from byte writes into a shadow copy. A commit then copies the shadow into the active copy that drives the network. It is generalised over neuron count, row depth and entry width, so entries may span several bytes.

## Interface
- `P_NUM_NEURONS`, default 5: total neurons.
- `P_NUM_INPUTS`, default 2: input neurons.
- `P_NUM_OUTPUTS`, default 1: output neurons.
- `P_TABLE_MAX_NUM_ROWS`, default 10: rows per table.
- `P_TABLE_WEIGHT_BW`, default 7: weight field width.
- `P_BASE_ADDR`, default 7'h60: base of the 4-register window.
- `L_TABLE_IDX_BW` (localparam) = $clog2(P_NUM_NEURONS-P_NUM_OUTPUTS+1).
- `L_ENTRY_BW` (localparam) = P_TABLE_WEIGHT_BW+L_TABLE_IDX_BW.
- `L_BYTES_PER_ENTRY` (localparam) = ceil(L_ENTRY_BW/8).
- `L_NUM_TABLES` (localparam) = P_NUM_NEURONS-P_NUM_INPUTS.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous and active-high.
- `prot_enable`  in  1  transaction strobe, one cycle per transaction.
- `prot_r0w1`  in  1  0 = read, 1 = write.
- `prot_addr`  in  7  register address.
- `prot_wdata`  in  8  write data.
- `prot_rdata`  out  8  read data; combinational, valid while `prot_enable`=1.
- `prot_hit`  out  1  combinational; `prot_addr` is in [P_BASE_ADDR, P_BASE_ADDR+3].
- `cfg_table_contents`  out  [L_NUM_TABLES:1][P_TABLE_MAX_NUM_ROWS-1:0][L_ENTRY_BW-1:0]  active tables.
- `cfg_update`  out  1  one-cycle pulse after each commit.

## Operation
Register offsets are relative to `P_BASE_ADDR`.

- **+0 TABLE_SEL**
  - Write 1..L_NUM_TABLES: selects the table, clears `row_ptr`, `byte_ptr` and the staging register.
  - Write of 0 or >L_NUM_TABLES: ignored and sets ERR.
  - Read: returns the current selection.
- **+1 ROW_PTR**
  - Write <P_TABLE_MAX_NUM_ROWS: sets `row_ptr`, clears `byte_ptr` and staging.
  - Write of any other value: ignored and sets ERR.
  - Read: returns `row_ptr`.
- **+2 DATA**
  - Write: stores the byte into staging at `byte_ptr`, LSB byte first.
  - On byte L_BYTES_PER_ENTRY-1: the staged entry is truncated to L_ENTRY_BW (upper bits dropped) and written to shadow[sel][row_ptr]. Then `byte_ptr`=0 and `row_ptr` increments, wrapping from P_TABLE_MAX_NUM_ROWS-1 to 0. DIRTY is set.
  - Otherwise: `byte_ptr` increments.
- **+3 CTRL**
  - Write bit0 COMMIT: active ← shadow, DIRTY cleared.
  - Write bit1 CLEAR: shadow ← 0, DIRTY set.
  - Write bit2 ERRCLR: ERR cleared.
  - Read: {4'b0, ERR, DIRTY, 1'b0, PARTIAL}, where PARTIAL = (`byte_ptr`≠0).
- Writes with `prot_hit`=0 are ignored. `prot_rdata`=8'h00 when `prot_hit`=0.
- COMMIT and CLEAR in the same write: active takes the pre-clear shadow, shadow is cleared, DIRTY=1.
- A DATA write that completes an entry while ERR=1 is still accepted. ERR is status only.

## Timing
- All state updates on the `clk` edge where `prot_enable`=1; no read latency.
- Commit: `cfg_table_contents` changes on the CTRL write edge. `cfg_update`=1 for exactly the following cycle.
- Back-to-back commits produce back-to-back pulses.
- Reset values:
  - shadow, active, staging, `row_ptr`, `byte_ptr`, ERR, DIRTY = 0.
  - TABLE_SEL = 1.
  - `cfg_update` = 0.
- Reset mid-entry discards the partial staging.
- `rst` asserted asynchronously forces all outputs to reset values immediately.

## Configuration
- `SN_CFG_READBACK_EN` defined:
  - A DATA read returns byte `byte_ptr` of shadow[sel][row_ptr].
  - The read advances `byte_ptr`/`row_ptr` exactly as a write does, but does not set DIRTY.
- Not defined:
  - A DATA read returns 8'h00 and has no side effects.
  - The shadow read mux is not built.

## Structure
- Package `sn_cfg_pkg` holds:
  - register offset constants (REG_TABLE_SEL, REG_ROW_PTR, REG_DATA, REG_CTRL);
  - CTRL/status bit positions;
  - a `bytes_per_entry(bw)` function.
- Sub-module `sn_cfg_byte_assembler` holds the staging register, `byte_ptr` and the `entry_done` strobe. It is parametrised by L_ENTRY_BW.

## Test plan
All scenarios use defaults: L_ENTRY_BW=10, 2 bytes/entry, 3 tables, base 0x60.

1. Reset → `cfg_table_contents` all 0; read 0x60 = 0x01; read 0x63 = 0x00; `cfg_update`=0.
2. Write 0x60=0x02, 0x62=0xAB, 0x62=0xFF → shadow[2][0]=10'h3AB; read 0x61 = 0x01; read 0x63 = 0x04; outputs unchanged. Then write 0x63=0x01 → `cfg_table_contents`[2][0]=10'h3AB and `cfg_update` high one cycle.
3. Write 0x61=0x09, then 4 DATA bytes 0x11,0x00,0x22,0x00 → rows 9 and 0 hold 0x011 and 0x022; read 0x61 = 0x01.
4. Write 0x60=0x04, then 0x61=0x0A → TABLE_SEL still 0x02, ROW_PTR unchanged, read 0x63 bit3=1. Write 0x63=0x04 → ERR=0.
5. Write 0x62=0x55, then 0x61=0x03, then 0x62=0x11, 0x62=0x02 → row 3=0x211 and no trace of 0x55. Assert `rst` after a single DATA byte → read 0x63 = 0x00.
6. After scenario 2, write 0x61=0x00 and read 0x62 twice → 0xAB, 0x03 with the macro (ROW_PTR then reads 1); 0x00, 0x00 with ROW_PTR still 0 without it.
